// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: the CPU owns the bus by default; a video DMA fetcher
// takes fixed-length read bursts, each followed by one guaranteed CPU cycle.
module ram_arbiter #(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned AW        = 16
) (
  input  logic          CLOCK,
  input  logic          CLEAR_N,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_d,
  output logic [7:0]    cpu_q,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_a,
  output logic          dma_ack,
  output logic          dma_valid,
  output logic [7:0]    dma_q,
  output logic          dma_done,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  input  logic [7:0]    ram_q
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DMA  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_cnt;
  logic          r_ack;
  logic          r_valid;
  logic          r_done;

  logic w_dma_owns;
  logic w_accept;
  logic w_last;

  assign w_dma_owns = (r_state == ST_DMA);
  assign w_accept   = (r_state == ST_IDLE) && dma_req;
  assign w_last     = w_dma_owns && (r_cnt == LAST_CNT);

  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Read data returns one cycle after each DMA read, so valid/done trail the bus by a cycle.
      r_ack   <= w_accept;
      r_valid <= w_dma_owns;
      r_done  <= w_last;
      case (r_state)
        ST_IDLE: begin
          if (dma_req) begin
            r_state <= ST_DMA;
            r_addr  <= dma_a;
            r_cnt   <= '0;
          end
        end
        ST_DMA: begin
          r_addr <= r_addr + AW'(1);
          r_cnt  <= r_cnt + 8'd1;
          if (w_last) begin
            r_state <= ST_GAP;
          end
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write takes priority when the CPU raises both strobes.
  always_comb begin
    ram_rd = cpu_rd & ~cpu_wr;
    ram_wr = cpu_wr;
    ram_a  = cpu_a;
    ram_d  = cpu_d;
    if (w_dma_owns) begin
      ram_rd = 1'b1;
      ram_wr = 1'b0;
      ram_a  = r_addr;
      ram_d  = '0;
    end
  end

  assign cpu_stall = w_dma_owns & (cpu_rd | cpu_wr);
  assign cpu_q     = ram_q;
  assign dma_q     = r_valid ? ram_q : '0;
  assign dma_ack   = r_ack;
  assign dma_valid = r_valid;
  assign dma_done  = r_done;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run,
// all compared against a burst/gap bookkeeping model and a shadow RAM image.
module tb_ram_arbiter;

  localparam int unsigned BL = 8;
  localparam int unsigned AW = 16;

  logic        CLOCK   = 1'b0;
  logic        CLEAR_N = 1'b0;
  logic        cpu_rd  = 1'b0;
  logic        cpu_wr  = 1'b0;
  logic [15:0] cpu_a   = '0;
  logic [7:0]  cpu_d   = '0;
  logic        dma_req = 1'b0;
  logic [15:0] dma_a   = '0;
  logic [7:0]  cpu_q, dma_q, ram_d;
  logic        cpu_stall, dma_ack, dma_valid, dma_done, ram_rd, ram_wr;
  logic [15:0] ram_a;
  logic [7:0]  ram_q = '0;
  logic [7:0]  mem [0:65535] = '{default: '0};

  int checks   = 0;
  int failures = 0;

  // reference model state
  int          m_left;
  bit          m_gap;
  logic [15:0] m_addr;
  bit          m_ack, m_valid, m_done;
  logic [7:0]  m_q = '0;
  logic [7:0]  m_mem [0:65535] = '{default: '0};
  logic        e_rd, e_wr, e_stall;
  logic [15:0] e_a;
  logic [7:0]  e_d;

  always #5 CLOCK = ~CLOCK;

  ram_arbiter #(.BURST_LEN(BL), .AW(AW)) dut (
    .CLOCK(CLOCK), .CLEAR_N(CLEAR_N),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_a(dma_a), .dma_ack(dma_ack), .dma_valid(dma_valid),
    .dma_q(dma_q), .dma_done(dma_done),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
  );

  // synchronous single-port RAM driven by the DUT
  always @(posedge CLOCK) begin
    if (ram_wr) mem[ram_a] <= ram_d;
    else if (ram_rd) ram_q <= mem[ram_a];
  end

  task automatic model_reset();
    m_left = 0; m_gap = 0; m_addr = '0;
    m_ack = 0; m_valid = 0; m_done = 0;
  endtask

  task automatic model_eval();
    if (m_left > 0) begin
      e_rd = 1'b1; e_wr = 1'b0; e_a = m_addr; e_d = 8'h00;
    end else begin
      e_rd = cpu_rd & ~cpu_wr; e_wr = cpu_wr; e_a = cpu_a; e_d = cpu_d;
    end
    e_stall = (m_left > 0) && (cpu_rd || cpu_wr);
  endtask

  task automatic model_commit();
    model_eval();
    if (e_wr) m_mem[e_a] = e_d;
    else if (e_rd) m_q = m_mem[e_a];
    if (!CLEAR_N) begin
      model_reset();
    end else begin
      m_valid = (m_left > 0);
      m_done  = (m_left == 1);
      m_ack   = 0;
      if (m_left > 0) begin
        m_addr = m_addr + 16'd1;
        m_left = m_left - 1;
        m_gap  = (m_left == 0);
      end else if (m_gap) begin
        m_gap = 0;
      end else if (dma_req) begin
        m_left = BL;
        m_addr = dma_a;
        m_ack  = 1;
      end
    end
  endtask

  task automatic sample();
    @(negedge CLOCK);
    model_eval();
  endtask

  task automatic advance();
    @(posedge CLOCK);
    model_commit();
    #1;
  endtask

  task automatic idle_cycles(input int unsigned n);
    cpu_rd = 0; cpu_wr = 0; dma_req = 0;
    for (int unsigned i = 0; i < n; i++) advance();
  endtask

  task automatic test_reset();
    CLEAR_N = 0; cpu_d = 8'hA5; cpu_a = 16'h2222; dma_req = 1; dma_a = 16'h1111;
    model_reset();
    sample();
    checks++;
    if ({dma_ack, dma_valid, dma_done, cpu_stall} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {dma_ack, dma_valid, dma_done, cpu_stall});
    end
    checks++;
    if (dma_q !== 8'h00) begin failures++; $display("FAIL reset_dma_q got=%h exp=00", dma_q); end
    checks++;
    if ({ram_rd, ram_wr, ram_a, ram_d} !== {1'b0, 1'b0, 16'h2222, 8'hA5}) begin
      failures++; $display("FAIL reset_passthru got=%b%b %h %h exp=00 2222 a5", ram_rd, ram_wr, ram_a, ram_d);
    end
    advance();
    sample();
    checks++;
    if ({dma_ack, ram_rd} !== 2'b00) begin failures++; $display("FAIL reset_req_ignored got=%b exp=00", {dma_ack, ram_rd}); end
    advance();
    CLEAR_N = 1; dma_req = 0;
    sample();
    checks++;
    if (dma_ack !== 1'b0) begin failures++; $display("FAIL reset_release_ack got=%b exp=0", dma_ack); end
    advance();
  endtask

  task automatic test_cpu_only();
    cpu_wr = 1; cpu_a = 16'h0123; cpu_d = 8'h5A;
    sample();
    checks++;
    if ({ram_wr, ram_rd, ram_a, ram_d, cpu_stall} !== {1'b1, 1'b0, 16'h0123, 8'h5A, 1'b0}) begin
      failures++; $display("FAIL cpu_write got=%b%b %h %h stall=%b exp=10 0123 5a stall=0", ram_wr, ram_rd, ram_a, ram_d, cpu_stall);
    end
    advance();
    cpu_wr = 0; cpu_rd = 1;
    sample();
    checks++;
    if ({ram_rd, ram_wr, ram_a, cpu_stall} !== {1'b1, 1'b0, 16'h0123, 1'b0}) begin
      failures++; $display("FAIL cpu_read got=%b%b %h stall=%b exp=10 0123 stall=0", ram_rd, ram_wr, ram_a, cpu_stall);
    end
    advance();
    cpu_rd = 0;
    sample();
    checks++;
    if ({cpu_q, cpu_stall} !== {8'h5A, 1'b0}) begin
      failures++; $display("FAIL cpu_rdata got=%h stall=%b exp=5a stall=0", cpu_q, cpu_stall);
    end
    advance();
  endtask

  task automatic test_single_burst();
    int unsigned acks = 0;
    int unsigned valids = 0;
    logic [15:0] ea;
    for (int unsigned k = 0; k < 12; k++) begin
      dma_req = (k == 0);
      dma_a   = (k == 0) ? 16'h0900 : 16'($urandom);
      sample();
      if (dma_ack) acks++;
      if (dma_valid) valids++;
      checks++;
      if (dma_ack !== (k == 1)) begin failures++; $display("FAIL burst_ack k=%0d got=%b exp=%b", k, dma_ack, (k == 1)); end
      if (k >= 1 && k <= 8) begin
        ea = 16'h0900 + 16'(k - 1);
        checks++;
        if ({ram_rd, ram_wr, ram_a} !== {1'b1, 1'b0, ea}) begin
          failures++; $display("FAIL burst_addr k=%0d got=%b%b %h exp=10 %h", k, ram_rd, ram_wr, ram_a, ea);
        end
      end
      checks++;
      if ({dma_valid, dma_done} !== {(k >= 2 && k <= 9), (k == 9)}) begin
        failures++; $display("FAIL burst_valid_done k=%0d got=%b%b exp=%b%b", k, dma_valid, dma_done, (k >= 2 && k <= 9), (k == 9));
      end
      if (dma_valid) begin
        checks++;
        if (dma_q !== m_q) begin failures++; $display("FAIL burst_data k=%0d got=%h exp=%h", k, dma_q, m_q); end
      end
      advance();
    end
    checks++;
    if (acks != 1 || valids != 8) begin failures++; $display("FAIL burst_counts acks=%0d valids=%0d exp=1,8", acks, valids); end
  endtask

  task automatic test_contention();
    int unsigned stalls = 0;
    logic [15:0] ea;
    dma_a = 16'h0400; dma_req = 1;
    sample();
    checks++;
    if (cpu_stall !== 1'b0) begin failures++; $display("FAIL cont_accept_stall got=%b exp=0", cpu_stall); end
    advance();
    dma_req = 0; cpu_wr = 1; cpu_rd = 1; cpu_a = 16'h0040; cpu_d = 8'hC3;
    for (int unsigned k = 1; k <= 9; k++) begin
      sample();
      if (cpu_stall) stalls++;
      checks++;
      if (cpu_stall !== (k <= 8)) begin failures++; $display("FAIL cont_stall k=%0d got=%b exp=%b", k, cpu_stall, (k <= 8)); end
      checks++;
      if (k <= 8) begin
        ea = 16'h0400 + 16'(k - 1);
        if ({ram_rd, ram_wr, ram_a} !== {1'b1, 1'b0, ea}) begin
          failures++; $display("FAIL cont_dma_bus k=%0d got=%b%b %h exp=10 %h", k, ram_rd, ram_wr, ram_a, ea);
        end
      end else if ({ram_rd, ram_wr, ram_a, ram_d} !== {1'b0, 1'b1, 16'h0040, 8'hC3}) begin
        failures++; $display("FAIL cont_gap_write got=%b%b %h %h exp=01 0040 c3", ram_rd, ram_wr, ram_a, ram_d);
      end
      advance();
    end
    cpu_wr = 0;
    sample();
    checks++;
    if ({cpu_stall, ram_rd} !== 2'b01) begin failures++; $display("FAIL cont_readback_issue got=%b exp=01", {cpu_stall, ram_rd}); end
    advance();
    cpu_rd = 0;
    sample();
    checks++;
    if (cpu_q !== 8'hC3) begin failures++; $display("FAIL cont_readback got=%h exp=c3", cpu_q); end
    advance();
    checks++;
    if (stalls != 8) begin failures++; $display("FAIL cont_stall_count got=%0d exp=8", stalls); end
  endtask

  task automatic test_wrap();
    logic [15:0] ea;
    for (int unsigned k = 0; k <= 10; k++) begin
      dma_req = (k == 0); dma_a = 16'hFFFE;
      sample();
      if (k >= 1 && k <= 8) begin
        ea = 16'hFFFE + 16'(k - 1);
        checks++;
        if ({ram_rd, ram_a} !== {1'b1, ea}) begin failures++; $display("FAIL wrap_addr k=%0d got=%b %h exp=1 %h", k, ram_rd, ram_a, ea); end
      end
      checks++;
      if (dma_done !== (k == 9)) begin failures++; $display("FAIL wrap_done k=%0d got=%b exp=%b", k, dma_done, (k == 9)); end
      advance();
    end
  endtask

  task automatic test_continuous();
    bit own;
    logic [15:0] ea;
    for (int unsigned k = 0; k <= 20; k++) begin
      dma_req = 1; dma_a = (k < 5) ? 16'h1200 : 16'h3400;
      cpu_rd = (k == 9); cpu_a = 16'h0040;
      sample();
      own = (k >= 1 && k <= 8) || (k >= 11 && k <= 18);
      checks++;
      if (own) begin
        ea = (k <= 8) ? 16'h1200 + 16'(k - 1) : 16'h3400 + 16'(k - 11);
        if ({ram_rd, ram_wr, ram_a} !== {1'b1, 1'b0, ea}) begin
          failures++; $display("FAIL cont_req_bus k=%0d got=%b%b %h exp=10 %h", k, ram_rd, ram_wr, ram_a, ea);
        end
      end else if (k == 9) begin
        if ({ram_rd, ram_wr, ram_a, cpu_stall} !== {1'b1, 1'b0, 16'h0040, 1'b0}) begin
          failures++; $display("FAIL cont_req_gap_read got=%b%b %h stall=%b exp=10 0040 stall=0", ram_rd, ram_wr, ram_a, cpu_stall);
        end
      end else if (ram_rd !== 1'b0) begin
        failures++; $display("FAIL cont_req_cpu_cycle k=%0d ram_rd got=%b exp=0", k, ram_rd);
      end
      checks++;
      if ({dma_ack, dma_valid} !== {(k == 1 || k == 11), ((k >= 2 && k <= 9) || (k >= 12 && k <= 19))}) begin
        failures++; $display("FAIL cont_req_ack_valid k=%0d got=%b%b", k, dma_ack, dma_valid);
      end
      if (k == 10) begin
        checks++;
        if (cpu_q !== 8'hC3) begin failures++; $display("FAIL cont_req_gap_data got=%h exp=c3", cpu_q); end
      end
      advance();
    end
    cpu_rd = 0;
    idle_cycles(12);
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] ea;
    dma_a = 16'h0500; dma_req = 1;
    sample();
    advance();
    dma_req = 0; cpu_wr = 1; cpu_a = 16'h0050; cpu_d = 8'h77;
    for (int unsigned k = 1; k <= 3; k++) begin
      sample();
      checks++;
      if ({cpu_stall, ram_a} !== {1'b1, 16'h0500 + 16'(k - 1)}) begin
        failures++; $display("FAIL rst_burst_pre k=%0d got=%b %h", k, cpu_stall, ram_a);
      end
      advance();
    end
    checks++;
    if (dma_valid !== 1'b1) begin failures++; $display("FAIL rst_valid_before got=%b exp=1", dma_valid); end
    CLEAR_N = 0;
    model_reset();
    #1;
    checks++;
    if ({dma_ack, dma_valid, dma_done, cpu_stall, dma_q} !== 12'h000) begin
      failures++; $display("FAIL rst_async_clear got=%b%b%b%b %h exp=0000 00", dma_ack, dma_valid, dma_done, cpu_stall, dma_q);
    end
    checks++;
    if ({ram_rd, ram_wr, ram_a, ram_d} !== {1'b0, 1'b1, 16'h0050, 8'h77}) begin
      failures++; $display("FAIL rst_async_passthru got=%b%b %h %h exp=01 0050 77", ram_rd, ram_wr, ram_a, ram_d);
    end
    dma_req = 1; dma_a = 16'h0A00; cpu_wr = 0;
    advance();
    advance();
    sample();
    checks++;
    if ({dma_valid, dma_done} !== 2'b00) begin failures++; $display("FAIL rst_hold got=%b%b exp=00", dma_valid, dma_done); end
    advance();
    CLEAR_N = 1;
    for (int unsigned k = 0; k < 12; k++) begin
      dma_req = (k == 0);
      sample();
      checks++;
      if ({dma_ack, dma_done} !== {(k == 1), (k == 9)}) begin
        failures++; $display("FAIL rst_restart_flags k=%0d got=%b%b exp=%b%b", k, dma_ack, dma_done, (k == 1), (k == 9));
      end
      if (k >= 1 && k <= 8) begin
        ea = 16'h0A00 + 16'(k - 1);
        checks++;
        if ({ram_rd, ram_a} !== {1'b1, ea}) begin failures++; $display("FAIL rst_restart_addr k=%0d got=%b %h exp=1 %h", k, ram_rd, ram_a, ea); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int unsigned n = 0; n < 800; n++) begin
      if (!CLEAR_N) begin
        CLEAR_N = 1;
      end else if ($urandom_range(0, 79) == 0) begin
        CLEAR_N = 0;
        model_reset();
      end
      cpu_rd  = ($urandom_range(0, 2) == 0);
      cpu_wr  = ($urandom_range(0, 3) == 0);
      cpu_a   = 16'h0500 + 16'($urandom_range(0, 31));
      cpu_d   = 8'($urandom);
      dma_req = ($urandom_range(0, 3) == 0);
      dma_a   = ($urandom_range(0, 5) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                            : 16'h04F0 + 16'($urandom_range(0, 63));
      sample();
      checks++;
      if ({ram_rd, ram_wr, ram_a, ram_d} !== {e_rd, e_wr, e_a, e_d}) begin
        failures++; $display("FAIL rand_bus n=%0d got=%b%b %h %h exp=%b%b %h %h", n, ram_rd, ram_wr, ram_a, ram_d, e_rd, e_wr, e_a, e_d);
      end
      checks++;
      if ({dma_ack, dma_valid, dma_done, cpu_stall} !== {m_ack, m_valid, m_done, e_stall}) begin
        failures++; $display("FAIL rand_flags n=%0d got=%b%b%b%b exp=%b%b%b%b", n, dma_ack, dma_valid, dma_done, cpu_stall, m_ack, m_valid, m_done, e_stall);
      end
      checks++;
      if (dma_q !== (m_valid ? m_q : 8'h00)) begin
        failures++; $display("FAIL rand_dma_q n=%0d got=%h exp=%h", n, dma_q, (m_valid ? m_q : 8'h00));
      end
      checks++;
      if (cpu_q !== m_q) begin failures++; $display("FAIL rand_cpu_q n=%0d got=%h exp=%h", n, cpu_q, m_q); end
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cpu_only();
    test_single_burst();
    test_contention();
    test_wrap();
    test_continuous();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
